// File: rtl/unisim_sram_b_param_pkg.sv
// Bank geometry shared by the tiled SRAM and its read pipeline.
// Build option: UNISIM_SRAM_B_BYPASS_EN adds same-address write forwarding.
package unisim_sram_b_param_pkg;

    localparam int BANK_DEPTH = 2048;
    localparam int BANK_WIDTH = 8;
    localparam int BANK_ABITS = 11;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/unisim_sram_b_param_if.sv
// Write/read port bundle for unisim_sram_b_param.
// Build option: UNISIM_SRAM_B_BYPASS_EN (no effect on the bundle itself).
interface unisim_sram_b_param_if #(
    parameter int ABITS = 12,
    parameter int DBITS = 16
) ();

    logic             CE0;
    logic [ABITS-1:0] A0;
    logic [DBITS-1:0] D0;
    logic             WE0;
    logic [DBITS-1:0] WEM0;
    logic             CE1;
    logic [ABITS-1:0] A1;
    logic [DBITS-1:0] Q1;
    logic             Q1_VALID;
    logic             ERR;

    modport master (
        output CE0, A0, D0, WE0, WEM0, CE1, A1,
        input  Q1, Q1_VALID, ERR
    );

    modport slave (
        input  CE0, A0, D0, WE0, WEM0, CE1, A1,
        output Q1, Q1_VALID, ERR
    );

endinterface

// File: rtl/unisim_sram_b_rdpipe.sv
// Read pipeline: valid / bank-select / forwarding registers aligned to RD_LAT.
// Build option: UNISIM_SRAM_B_BYPASS_EN enables the forwarding stage.
module unisim_sram_b_rdpipe
    import unisim_sram_b_param_pkg::*;
#(
    parameter int DBITS  = 16,
    parameter int PW     = 16,
    parameter int VB     = 2,
    parameter int VSW    = 1,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_fire,
    input  logic             rd_oor,
    input  logic [VSW-1:0]   rd_vsel,
    input  logic [VB*PW-1:0] bank_flat,
`ifdef UNISIM_SRAM_B_BYPASS_EN
    input  logic             byp_hit,
    input  logic [DBITS-1:0] byp_data,
    input  logic [DBITS-1:0] byp_mask,
`endif
    output logic [DBITS-1:0] q,
    output logic             q_valid
);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_oor_q, s1_oor_d;
    logic [VSW-1:0]   s1_vsel_q, s1_vsel_d;
    logic [DBITS-1:0] s1_data;
    logic [DBITS-1:0] data_q, data_d;

    always_comb begin
        s1_valid_d = rd_fire;
        s1_oor_d   = rd_oor;
        s1_vsel_d  = rd_vsel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_oor_q   <= 1'b0;
            s1_vsel_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_oor_q   <= s1_oor_d;
            s1_vsel_q  <= s1_vsel_d;
        end
    end

`ifdef UNISIM_SRAM_B_BYPASS_EN
    logic             s1_hit_q, s1_hit_d;
    logic [DBITS-1:0] s1_bd_q, s1_bd_d;
    logic [DBITS-1:0] s1_bm_q, s1_bm_d;

    always_comb begin
        s1_hit_d = byp_hit;
        s1_bd_d  = byp_data;
        s1_bm_d  = byp_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit_q <= 1'b0;
            s1_bd_q  <= '0;
            s1_bm_q  <= '0;
        end else begin
            s1_hit_q <= s1_hit_d;
            s1_bd_q  <= s1_bd_d;
            s1_bm_q  <= s1_bm_d;
        end
    end
`endif

    // Bank output is read-first old data; forwarding merges the colliding write on top.
    always_comb begin
        s1_data = '0;
        for (int v = 0; v < VB; v++) begin
            if (s1_vsel_q == VSW'(v)) s1_data = bank_flat[v*PW +: DBITS];
        end
`ifdef UNISIM_SRAM_B_BYPASS_EN
        if (s1_hit_q) s1_data = (s1_bd_q & s1_bm_q) | (s1_data & ~s1_bm_q);
`endif
        if (s1_oor_q) s1_data = '0;
    end

    always_comb begin
        data_d = s1_valid_q ? s1_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic s2_valid_q, s2_valid_d;

            always_comb s2_valid_d = s1_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) s2_valid_q <= 1'b0;
                else        s2_valid_q <= s2_valid_d;
            end

            assign q       = data_q;
            assign q_valid = s2_valid_q;
        end else begin : g_lat1
            // data_q only holds the last value here; fresh data bypasses it.
            assign q       = s1_valid_q ? s1_data : data_q;
            assign q_valid = s1_valid_q;
        end
    endgenerate

endmodule

// File: rtl/unisim_sram_b_param.sv
// Parameterised SRAM tiled from 2048x8 dual-port banks, bit-masked writes, sticky ERR.
// Build option: UNISIM_SRAM_B_BYPASS_EN forwards a same-address write to the read.
module unisim_sram_b_param
    import unisim_sram_b_param_pkg::*;
#(
    parameter int ABITS  = 12,
    parameter int DBITS  = 16,
    parameter int WORDS  = 4096,
    parameter int RD_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    unisim_sram_b_param_if.slave  bus
);

    localparam int HB  = ceil_div(DBITS, BANK_WIDTH);
    localparam int VB  = ceil_div(WORDS, BANK_DEPTH);
    localparam int VSW = (VB > 1) ? $clog2(VB) : 1;
    localparam int PW  = HB * BANK_WIDTH;
    localparam logic [ABITS:0] WORDS_LIM = (ABITS+1)'(WORDS);

    logic                  wr_in_range, rd_in_range;
    logic                  wr_en, rd_en;
    logic [VSW-1:0]        wr_vsel, rd_vsel;
    logic [BANK_ABITS-1:0] wr_addr, rd_addr;
    logic [PW-1:0]         wr_data, wr_mask;
    logic [VB*PW-1:0]      bank_flat;
    logic                  err_q, err_d;

    // Padding lanes take mask 1 / data 0 so unused bank bits are written as zero.
    always_comb begin
        wr_in_range = ({1'b0, bus.A0} < WORDS_LIM);
        rd_in_range = ({1'b0, bus.A1} < WORDS_LIM);
        wr_vsel     = VSW'(bus.A0 >> BANK_ABITS);
        rd_vsel     = VSW'(bus.A1 >> BANK_ABITS);
        wr_addr     = BANK_ABITS'(bus.A0);
        rd_addr     = BANK_ABITS'(bus.A1);
        wr_data     = PW'(bus.D0);
        wr_mask     = ~PW'(~bus.WEM0);
        wr_en       = RSTN && bus.CE0 && bus.WE0 && wr_in_range;
        rd_en       = RSTN && bus.CE1 && rd_in_range;
    end

    generate
        for (genvar gi = 0; gi < VB; gi++) begin : g_vbank
            for (genvar gk = 0; gk < HB; gk++) begin : g_hbank
                logic [BANK_WIDTH-1:0] mem [BANK_DEPTH];
                logic [BANK_WIDTH-1:0] rd_q;
                logic [BANK_WIDTH-1:0] lane_d, lane_m;
                logic                  lane_we, lane_re;

                assign lane_d  = wr_data[gk*BANK_WIDTH +: BANK_WIDTH];
                assign lane_m  = wr_mask[gk*BANK_WIDTH +: BANK_WIDTH];
                assign lane_we = wr_en && (wr_vsel == VSW'(gi));
                assign lane_re = rd_en && (rd_vsel == VSW'(gi));

                always_ff @(posedge CLK) begin
                    if (lane_we) mem[wr_addr] <= (mem[wr_addr] & ~lane_m) | (lane_d & lane_m);
                end

                always_ff @(posedge CLK) begin
                    if (lane_re) rd_q <= mem[rd_addr];
                end

                assign bank_flat[gi*PW + gk*BANK_WIDTH +: BANK_WIDTH] = rd_q;
            end
        end
    endgenerate

`ifdef UNISIM_SRAM_B_BYPASS_EN
    logic byp_hit;
    assign byp_hit = wr_en && bus.CE1 && (bus.A0 == bus.A1);
`endif

    unisim_sram_b_rdpipe #(
        .DBITS  (DBITS),
        .PW     (PW),
        .VB     (VB),
        .VSW    (VSW),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk       (CLK),
        .rst_n     (RSTN),
        .rd_fire   (bus.CE1),
        .rd_oor    (bus.CE1 && !rd_in_range),
        .rd_vsel   (rd_vsel),
        .bank_flat (bank_flat),
`ifdef UNISIM_SRAM_B_BYPASS_EN
        .byp_hit   (byp_hit),
        .byp_data  (bus.D0),
        .byp_mask  (bus.WEM0),
`endif
        .q         (bus.Q1),
        .q_valid   (bus.Q1_VALID)
    );

    always_comb begin
        err_d = err_q;
        if ((bus.CE0 && !wr_in_range) || (bus.CE1 && !rd_in_range)) err_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.ERR = err_q;

endmodule

// File: tb/tb_unisim_sram_b_param.sv
// Bench: two instances (WORDS=3000/RD_LAT=1 and WORDS=4096/RD_LAT=2) driven identically,
// each checked against an array/queue reference model. Honours UNISIM_SRAM_B_BYPASS_EN.
module tb_unisim_sram_b_param;

    localparam int AB   = 12;
    localparam int DB   = 16;
    localparam int NDUT = 2;

    typedef struct {
        bit            v;
        bit            chk;
        logic [DB-1:0] d;
    } exp_t;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          ce0 = 1'b0, we0 = 1'b0, ce1 = 1'b0;
    logic [AB-1:0] a0 = '0, a1 = '0;
    logic [DB-1:0] d0 = '0, wem0 = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unisim_sram_b_param_if #(.ABITS(AB), .DBITS(DB)) bus1 ();
    unisim_sram_b_param_if #(.ABITS(AB), .DBITS(DB)) bus2 ();

    assign bus1.CE0 = ce0;  assign bus2.CE0 = ce0;
    assign bus1.A0  = a0;   assign bus2.A0  = a0;
    assign bus1.D0  = d0;   assign bus2.D0  = d0;
    assign bus1.WE0 = we0;  assign bus2.WE0 = we0;
    assign bus1.WEM0 = wem0; assign bus2.WEM0 = wem0;
    assign bus1.CE1 = ce1;  assign bus2.CE1 = ce1;
    assign bus1.A1  = a1;   assign bus2.A1  = a1;

    unisim_sram_b_param #(.ABITS(AB), .DBITS(DB), .WORDS(3000), .RD_LAT(1)) dut1 (
        .CLK (clk), .RSTN (rstn), .bus (bus1)
    );

    unisim_sram_b_param #(.ABITS(AB), .DBITS(DB), .WORDS(4096), .RD_LAT(2)) dut2 (
        .CLK (clk), .RSTN (rstn), .bus (bus2)
    );

    // Reference model state
    logic [DB-1:0] mem_m   [NDUT][4096];
    bit            known_m [NDUT][4096];
    exp_t          pipe_m  [NDUT][$];
    logic [DB-1:0] last_m  [NDUT];
    bit            last_ok [NDUT];
    bit            err_m   [NDUT];

    function automatic int words_of(input int k);
        return (k == 0) ? 3000 : 4096;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic get_out(input int k, output logic [DB-1:0] q, output logic v, output logic e);
        if (k == 0) begin q = bus1.Q1; v = bus1.Q1_VALID; e = bus1.ERR; end
        else        begin q = bus2.Q1; v = bus2.Q1_VALID; e = bus2.ERR; end
    endtask

    task automatic model_reset();
        exp_t idle_e;
        idle_e = '{v: 1'b0, chk: 1'b0, d: '0};
        for (int k = 0; k < NDUT; k++) begin
            pipe_m[k].delete();
            for (int i = 0; i < lat_of(k) - 1; i++) pipe_m[k].push_back(idle_e);
            last_m[k]  = '0;
            last_ok[k] = 1'b1;
            err_m[k]   = 1'b0;
        end
    endtask

    task automatic model_edge(input int k);
        exp_t e;
        e = '{v: 1'b0, chk: 1'b0, d: '0};
        if (rstn) begin
            if (ce1) begin
                e.v = 1'b1;
                if (int'(a1) >= words_of(k)) begin
                    e.chk    = 1'b1;
                    err_m[k] = 1'b1;
                end else begin
                    e.chk = known_m[k][a1];
                    e.d   = mem_m[k][a1];
`ifdef UNISIM_SRAM_B_BYPASS_EN
                    if (ce0 && we0 && a0 == a1) begin
                        e.d   = (d0 & wem0) | (e.d & ~wem0);
                        e.chk = e.chk || (wem0 == '1);
                    end
`endif
                end
            end
            if (ce0) begin
                if (int'(a0) >= words_of(k)) err_m[k] = 1'b1;
                else if (we0) begin
                    mem_m[k][a0] = (mem_m[k][a0] & ~wem0) | (d0 & wem0);
                    if (wem0 == '1) known_m[k][a0] = 1'b1;
                end
            end
        end
        pipe_m[k].push_back(e);
    endtask

    task automatic compare_out(input int k);
        exp_t          e;
        logic [DB-1:0] q;
        logic          v, er;
        e = pipe_m[k].pop_front();
        get_out(k, q, v, er);
        check_val($sformatf("valid%0d", k), 64'(v), 64'(e.v));
        if (e.v) begin
            if (e.chk) check_val($sformatf("q%0d", k), 64'(q), 64'(e.d));
            last_m[k]  = e.d;
            last_ok[k] = e.chk;
        end else if (last_ok[k]) begin
            check_val($sformatf("hold%0d", k), 64'(q), 64'(last_m[k]));
        end
        check_val($sformatf("err%0d", k), 64'(er), 64'(err_m[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) model_edge(k);
        #1;
        for (int k = 0; k < NDUT; k++) compare_out(k);
    endtask

    task automatic drive(input logic c0, input logic [AB-1:0] wa, input logic [DB-1:0] wd,
                         input logic w, input logic [DB-1:0] m, input logic c1,
                         input logic [AB-1:0] ra);
        ce0 = c0; a0 = wa; d0 = wd; we0 = w; wem0 = m; ce1 = c1; a1 = ra;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    function automatic logic [AB-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return AB'($urandom_range(0, 7));
            1:       return AB'(32'h800 + $urandom_range(0, 7));
            2:       return AB'(2998 + $urandom_range(0, 3));
            default: return AB'(32'h010);
        endcase
    endfunction

    logic [DB-1:0] qs   [6];
    logic          vs   [6];
    logic [DB-1:0] exp_byp;
    logic [DB-1:0] oq;
    logic          ov, oe;

    initial begin
        model_reset();
        idle();
        tick(); tick();
        rstn = 1'b1;

        // Full-width write then read
        drive(1'b1, 12'h005, 16'hBEEF, 1'b1, 16'hFFFF, 1'b0, '0); tick();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 12'h005); tick();
        check_val("beef_valid", 64'(bus1.Q1_VALID), 64'd1);
        check_val("beef_q", 64'(bus1.Q1), 64'hBEEF);
        idle(); tick(); tick();

        // Masked merge in vertical bank 1
        drive(1'b1, 12'h800, 16'h1234, 1'b1, 16'hFFFF, 1'b0, '0); tick();
        drive(1'b1, 12'h800, 16'hABCD, 1'b1, 16'h00FF, 1'b0, '0); tick();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 12'h800); tick();
        check_val("merge_q", 64'(bus1.Q1), 64'h12CD);

        // Same-address write and read in one cycle
        drive(1'b1, 12'h010, 16'h0000, 1'b1, 16'hFFFF, 1'b0, '0); tick();
        drive(1'b1, 12'h010, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 12'h010); tick();
`ifdef UNISIM_SRAM_B_BYPASS_EN
        exp_byp = 16'h5555;
`else
        exp_byp = 16'h0000;
`endif
        check_val("collide_q", 64'(bus1.Q1), 64'(exp_byp));
        idle(); tick(); tick();

        // Out-of-range read and write on the 3000-word instance
        check_val("err_pre", 64'(bus1.ERR), 64'd0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 12'd3000); tick();
        check_val("oor_q", 64'(bus1.Q1), 64'd0);
        check_val("oor_valid", 64'(bus1.Q1_VALID), 64'd1);
        check_val("oor_err", 64'(bus1.ERR), 64'd1);
        drive(1'b1, 12'd3000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, '0); tick();
        idle(); tick(); tick();
        check_val("oor_err_held", 64'(bus1.ERR), 64'd1);

        // Back-to-back reads through the two-cycle instance
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AB'(i), DB'(16'h1000 + i), 1'b1, 16'hFFFF, 1'b0, '0); tick();
        end
        idle(); tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b0, '0, '0, 1'b0, '0, 1'b1, AB'(i));
            else       idle();
            tick();
            vs[i] = bus2.Q1_VALID;
            qs[i] = bus2.Q1;
        end
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("lat2_valid[%0d]", i), 64'(vs[i]), 64'((i >= 1 && i <= 4) ? 1 : 0));
            if (i >= 1 && i <= 4)
                check_val($sformatf("lat2_q[%0d]", i), 64'(qs[i]), 64'(16'h1000 + i - 1));
        end

        // Reset with a read in flight
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 12'h005); tick();
        rstn = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            get_out(k, oq, ov, oe);
            check_val($sformatf("rst_q%0d", k), 64'(oq), 64'd0);
            check_val($sformatf("rst_valid%0d", k), 64'(ov), 64'd0);
            check_val($sformatf("rst_err%0d", k), 64'(oe), 64'd0);
        end
        drive(1'b1, 12'h005, 16'h0BAD, 1'b1, 16'hFFFF, 1'b1, 12'h005); tick();
        tick();
        rstn = 1'b1;
        drive(1'b1, 12'h020, 16'hC0DE, 1'b1, 16'hFFFF, 1'b0, '0); tick();
        check_val("rst_nopulse", 64'(bus2.Q1_VALID), 64'd0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 12'h020); tick();
        check_val("first_access_q", 64'(bus1.Q1), 64'hC0DE);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 12'h005); tick();
        check_val("mem_kept_q", 64'(bus1.Q1), 64'hBEEF);
        idle(); tick(); tick();

        // Random traffic over a small address pool
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, AB'(i), DB'($urandom), 1'b1, 16'hFFFF, 1'b0, '0); tick();
            drive(1'b1, AB'(32'h800 + i), DB'($urandom), 1'b1, 16'hFFFF, 1'b0, '0); tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AB'(2998 + i), DB'($urandom), 1'b1, 16'hFFFF, 1'b0, '0); tick();
        end
        for (int i = 0; i < 400; i++) begin
            ce0  = 1'($urandom_range(0, 1));
            we0  = ($urandom_range(0, 3) != 0);
            a0   = pick_addr();
            d0   = DB'($urandom);
            wem0 = ($urandom_range(0, 1) != 0) ? 16'hFFFF : DB'($urandom);
            ce1  = 1'($urandom_range(0, 1));
            a1   = ($urandom_range(0, 2) == 0) ? a0 : pick_addr();
            tick();
        end
        idle(); tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unisim_sram_b_param.md
UNISIM_SRAM_B_PARAM -- requirements
Module: unisim_sram_b_param

Interface
REQ-001 The block SHALL have parameter ABITS, default 12, address width of both ports.
REQ-002 The block SHALL have parameter DBITS, default 16, data width; any value 1..64.
REQ-003 The block SHALL have parameter WORDS, default 4096, logical depth; 1 <= WORDS <= 2^ABITS.
REQ-004 The block SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 The block SHALL have port CLK, input, 1, sole clock.
REQ-006 The block SHALL have port RSTN, input, 1, reset, asynchronous, active-low.
REQ-007 The block SHALL have port CE0, input, 1, write-port enable.
REQ-008 The block SHALL have port A0, input, ABITS, write address.
REQ-009 The block SHALL have port D0, input, DBITS, write data.
REQ-010 The block SHALL have port WE0, input, 1, write strobe.
REQ-011 The block SHALL have port WEM0, input, DBITS, per-bit write mask, 1 = write.
REQ-012 The block SHALL have port CE1, input, 1, read-port enable.
REQ-013 The block SHALL have port A1, input, ABITS, read address.
REQ-014 The block SHALL have port Q1, output, DBITS, read data.
REQ-015 The block SHALL have port Q1_VALID, output, 1, Q1 holds data from a read issued RD_LAT cycles earlier.
REQ-016 The block SHALL have port ERR, output, 1, sticky out-of-range access flag.

Function
REQ-017 Storage SHALL be tiled from 2048x8 dual-port BRAM banks: HB = ceil(DBITS/8) horizontal, VB = ceil(WORDS/2048) vertical; unused top bits of the last horizontal bank SHALL be written 0 and ignored on read.
REQ-018 Vertical bank SHALL be selected by A[ABITS-1:11] (0 when ABITS <= 11); bank address SHALL be A[min(ABITS,11)-1:0], zero-extended.
REQ-019 Write: CE0=1, WE0=1, A0<WORDS SHALL update only bits with WEM0=1 at the rising edge; CE0=1, WE0=0 SHALL be a no-op.
REQ-020 Read: CE1=1, A1<WORDS SHALL present mem[A1] on Q1 with Q1_VALID=1 exactly RD_LAT cycles later; the vertical-bank select SHALL be pipelined alongside.
REQ-021 RD_LAT=2 SHALL add one output register stage; reads SHALL be fully pipelined, one per cycle, no bubbles.
REQ-022 With no read in flight Q1_VALID SHALL be 0 and Q1 SHALL hold its last valid value.
REQ-023 Out-of-range (A>=WORDS) access with CE asserted: write SHALL be dropped, read SHALL return Q1=0 with Q1_VALID=1, ERR SHALL set next cycle and stay 1 until reset.
REQ-024 Simultaneous write and read, same address: result per REQ-033/REQ-034; different addresses, including the same bank, SHALL both complete normally.

Reset
REQ-025 On RSTN=0, asynchronously: Q1=0, Q1_VALID=0, ERR=0, all read-pipeline valid and select registers cleared.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 A read in flight when RSTN asserts SHALL be discarded; no Q1_VALID pulse after release.
REQ-028 Accesses presented while RSTN=0 SHALL be ignored.
REQ-029 First access SHALL be accepted on the first rising edge after RSTN deasserts.

Configuration
REQ-030 The write-forwarding feature SHALL be controlled by the macro UNISIM_SRAM_B_BYPASS_EN.
REQ-031 The same-address case SHALL be CE0=1, WE0=1, CE1=1, A0=A1<WORDS in one cycle.
REQ-032 Detection SHALL be registered and aligned to RD_LAT.
REQ-033 With UNISIM_SRAM_B_BYPASS_EN defined, the same-address case SHALL return Q1 = (D0 & WEM0) | (old & ~WEM0).
REQ-034 Without UNISIM_SRAM_B_BYPASS_EN, the same-address case SHALL return old data (read-first) and no bypass logic SHALL be synthesised.

Structure
REQ-035 A shared package SHALL hold the bank geometry constants (2048 depth, 8 width, 11 bank address bits) and a ceil-div function for HB/VB.
REQ-036 One sub-module, unisim_sram_b_rdpipe, SHALL implement the RD_LAT valid/select/bypass pipeline; bank instances SHALL live in the top level.

Verification
REQ-037 The bench SHALL cover: DBITS=16, write A0=0x005 D0=0xBEEF WEM0=0xFFFF, then read A1=0x005 -> Q1=0xBEEF, Q1_VALID high 1 cycle after CE1 (RD_LAT=1).
REQ-038 The bench SHALL cover: mask merge, mem[0x800]=0x1234, write D0=0xABCD WEM0=0x00FF, read -> Q1=0x12CD; exercises vertical bank 1.
REQ-039 The bench SHALL cover: same cycle write 0x5555 mask 0xFFFF and read at 0x010, old 0x0000 -> Q1=0x5555 with BYPASS_EN, 0x0000 without.
REQ-040 The bench SHALL cover: WORDS=3000, read A1=3000 -> Q1=0, Q1_VALID=1, ERR=1 next cycle and held; write A0=3000 leaves mem unchanged.
REQ-041 The bench SHALL cover: RD_LAT=2, back-to-back reads 0,1,2,3 -> Q1 stream in order, Q1_VALID high 4 consecutive cycles starting 2 cycles after the first read.
REQ-042 The bench SHALL cover: RSTN asserted the cycle after CE1 -> Q1=0, Q1_VALID=0, ERR=0 immediately; no valid pulse after release.
